// File: rtl/axi4_master_adapter_if.sv
// AXI4 bus bundle between the command adapter (master) and an AXI slave.
// One instance carries all five channels for a single outstanding burst.
interface axi4_master_adapter_if #(
   parameter int D_WIDTH     = 32,
   parameter int AXI_A_WIDTH = 32
);
   logic [3:0]             awid;
   logic [AXI_A_WIDTH-1:0] awaddr;
   logic [7:0]             awlen;
   logic [2:0]             awsize;
   logic [1:0]             awburst;
   logic [1:0]             awlock;
   logic [2:0]             awprot;
   logic                   awvalid;
   logic                   awready;

   logic [3:0]             wid;
   logic [D_WIDTH-1:0]     wdata;
   logic [D_WIDTH/8-1:0]   wstrb;
   logic                   wlast;
   logic                   wvalid;
   logic                   wready;

   logic [3:0]             bid;
   logic [1:0]             bresp;
   logic                   bvalid;
   logic                   bready;

   logic [3:0]             arid;
   logic [AXI_A_WIDTH-1:0] araddr;
   logic [7:0]             arlen;
   logic [2:0]             arsize;
   logic [1:0]             arburst;
   logic [1:0]             arlock;
   logic [2:0]             arprot;
   logic                   arvalid;
   logic                   arready;

   logic [3:0]             rid;
   logic [D_WIDTH-1:0]     rdata;
   logic [1:0]             rresp;
   logic                   rlast;
   logic                   rvalid;
   logic                   rready;

   modport master (
      output awid, awaddr, awlen, awsize, awburst, awlock, awprot, awvalid,
      input  awready,
      output wid, wdata, wstrb, wlast, wvalid,
      input  wready,
      input  bid, bresp, bvalid,
      output bready,
      output arid, araddr, arlen, arsize, arburst, arlock, arprot, arvalid,
      input  arready,
      input  rid, rdata, rresp, rlast, rvalid,
      output rready
   );

   modport slave (
      input  awid, awaddr, awlen, awsize, awburst, awlock, awprot, awvalid,
      output awready,
      input  wid, wdata, wstrb, wlast, wvalid,
      output wready,
      output bid, bresp, bvalid,
      input  bready,
      input  arid, araddr, arlen, arsize, arburst, arlock, arprot, arvalid,
      output arready,
      output rid, rdata, rresp, rlast, rvalid,
      input  rready
   );
endinterface

// File: rtl/axi4_master_adapter.sv
// Converts single burst commands plus write/read data streams into AXI4 INCR bursts,
// one command outstanding, reporting completion with a done pulse and an error flag.
module axi4_master_adapter #(
   parameter int         D_WIDTH     = 32,
   parameter int         AXI_A_WIDTH = 32,
   parameter logic [3:0] MASTER_ID   = 4'h0
) (
   input  logic                   aclk,
   input  logic                   aresetn,
   axi4_master_adapter_if.master  axi,
   input  logic                   cmd_valid_i,
   output logic                   cmd_ready_o,
   input  logic                   cmd_write_i,
   input  logic [AXI_A_WIDTH-1:0] cmd_addr_i,
   input  logic [7:0]             cmd_len_i,
   input  logic [D_WIDTH-1:0]     wr_data_i,
   input  logic [D_WIDTH/8-1:0]   wr_strb_i,
   input  logic                   wr_valid_i,
   output logic                   wr_ready_o,
   output logic [D_WIDTH-1:0]     rd_data_o,
   output logic                   rd_valid_o,
   input  logic                   rd_ready_i,
   output logic                   done_o,
   output logic                   error_o
);
   localparam int BYTES = D_WIDTH / 8;
   localparam int SZ    = $clog2(BYTES);
   localparam logic [AXI_A_WIDTH-1:0] LOW_MASK = AXI_A_WIDTH'(BYTES - 1);

   typedef enum logic [2:0] {IDLE, AW, W, B, AR, R, ERR} state_t;

   state_t                 state_q, state_d;
   logic [AXI_A_WIDTH-1:0] addr_q, addr_d;
   logic [7:0]             len_q, len_d;
   logic [7:0]             count_q, count_d;
   logic                   error_q, error_d;

   logic [AXI_A_WIDTH-1:0] cmd_addr_al;
   logic [12:0]            span_end;
   logic                   crosses;
   logic                   w_hs, r_hs, r_beat_err, b_err;

   // Byte just past the burst, relative to the 4KB page the burst starts in
   assign cmd_addr_al = cmd_addr_i & ~LOW_MASK;
   assign span_end    = {1'b0, cmd_addr_al[11:0]} + (({5'd0, cmd_len_i} + 13'd1) << SZ);
   assign crosses     = span_end > 13'd4096;

   assign w_hs = (state_q == W) && wr_valid_i && axi.wready;
   assign r_hs = (state_q == R) && axi.rvalid && rd_ready_i;

   // SLVERR/DECERR are the responses with bit 1 set
   assign b_err      = (axi.bresp >= 2'b10) || (axi.bid != MASTER_ID);
   assign r_beat_err = (axi.rresp >= 2'b10) || (axi.rid != MASTER_ID)
                     || (axi.rlast && (count_q < len_q))
                     || (!axi.rlast && (count_q > len_q));

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         state_q <= IDLE;
         addr_q  <= '0;
         len_q   <= '0;
         count_q <= '0;
         error_q <= 1'b0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         len_q   <= len_d;
         count_q <= count_d;
         error_q <= error_d;
      end
   end

   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      len_d   = len_q;
      count_d = count_q;
      error_d = error_q;
      done_o  = 1'b0;

      // Saturate so surplus read beats cannot wrap back under len
      if ((w_hs || r_hs) && (count_q != 8'hFF)) begin
         count_d = count_q + 8'd1;
      end

      unique case (state_q)
         IDLE: begin
            if (cmd_valid_i) begin
               addr_d  = cmd_addr_al;
               len_d   = cmd_len_i;
               count_d = 8'd0;
               error_d = crosses;
               if (crosses)          state_d = ERR;
               else if (cmd_write_i) state_d = AW;
               else                  state_d = AR;
            end
         end
         ERR: begin
            done_o  = 1'b1;
            state_d = IDLE;
         end
         AW: if (axi.awready) state_d = W;
         W:  if (w_hs && (count_q == len_q)) state_d = B;
         B: begin
            if (axi.bvalid) begin
               done_o  = 1'b1;
               error_d = b_err;
               state_d = IDLE;
            end
         end
         AR: if (axi.arready) state_d = R;
         R: begin
            if (r_hs) begin
               error_d = error_q | r_beat_err;
               if (axi.rlast) begin
                  done_o  = 1'b1;
                  state_d = IDLE;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // The completing beat/response is reflected in error during the done cycle itself
   assign error_o     = done_o ? error_d : error_q;
   assign cmd_ready_o = (state_q == IDLE);

   assign axi.awid    = MASTER_ID;
   assign axi.awaddr  = addr_q;
   assign axi.awlen   = len_q;
   assign axi.awsize  = 3'(SZ);
   assign axi.awburst = 2'b01;
   assign axi.awlock  = 2'b00;
   assign axi.awprot  = 3'b000;
   assign axi.awvalid = (state_q == AW);

   assign axi.wid     = MASTER_ID;
   assign axi.wdata   = wr_data_i;
   assign axi.wstrb   = wr_strb_i;
   assign axi.wlast   = (count_q == len_q);
   assign axi.wvalid  = (state_q == W) && wr_valid_i;
   assign wr_ready_o  = (state_q == W) && axi.wready;

   assign axi.bready  = (state_q == B);

   assign axi.arid    = MASTER_ID;
   assign axi.araddr  = addr_q;
   assign axi.arlen   = len_q;
   assign axi.arsize  = 3'(SZ);
   assign axi.arburst = 2'b01;
   assign axi.arlock  = 2'b00;
   assign axi.arprot  = 3'b000;
   assign axi.arvalid = (state_q == AR);

   assign axi.rready  = (state_q == R) && rd_ready_i;
   assign rd_valid_o  = (state_q == R) && axi.rvalid;
   assign rd_data_o   = axi.rdata;
endmodule

// File: tb/tb_axi4_master_adapter.sv
// Directed plus randomized bench for axi4_master_adapter; a task-level AXI slave and
// a burst-level reference model supply every expected value.
module tb_axi4_master_adapter;
   localparam int         DW  = 32;
   localparam int         AWD = 32;
   localparam logic [3:0] MID = 4'h0;

   logic aclk = 1'b0;
   logic aresetn = 1'b0;
   always #5 aclk = ~aclk;

   axi4_master_adapter_if #(.D_WIDTH(DW), .AXI_A_WIDTH(AWD)) axi ();

   logic            cmd_valid, cmd_ready, cmd_write;
   logic [AWD-1:0]  cmd_addr;
   logic [7:0]      cmd_len;
   logic [DW-1:0]   wr_data, rd_data;
   logic [DW/8-1:0] wr_strb;
   logic            wr_valid, wr_ready, rd_valid, rd_ready, done, error;

   int n_cmp = 0;
   int n_err = 0;

   axi4_master_adapter #(.D_WIDTH(DW), .AXI_A_WIDTH(AWD), .MASTER_ID(MID)) dut (
      .aclk(aclk), .aresetn(aresetn), .axi(axi),
      .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready), .cmd_write_i(cmd_write),
      .cmd_addr_i(cmd_addr), .cmd_len_i(cmd_len),
      .wr_data_i(wr_data), .wr_strb_i(wr_strb), .wr_valid_i(wr_valid), .wr_ready_o(wr_ready),
      .rd_data_o(rd_data), .rd_valid_o(rd_valid), .rd_ready_i(rd_ready),
      .done_o(done), .error_o(error)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge aclk);
      #1;
   endtask

   // 0: always ready, 1: toggling 1/0, 2: random
   function automatic logic pick(input int mode, input int cyc);
      if (mode == 0) return 1'b1;
      if (mode == 1) return (cyc % 2) == 0;
      return 1'($urandom_range(0, 1));
   endfunction

   function automatic bit crosses_4k(input logic [AWD-1:0] al, input logic [7:0] len);
      return (int'(al[11:0]) + (int'(len) + 1) * (DW / 8)) > 4096;
   endfunction

   task automatic issue_cmd(input bit wr, input logic [AWD-1:0] addr, input logic [7:0] len);
      cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_len = len;
      #2;
      chk("cmd_ready", cmd_ready, 1);
      tick();
      cmd_valid = 1'b0; cmd_addr = $urandom; cmd_len = 8'($urandom);
   endtask

   task automatic check_err_cmd();
      #2;
      chk("err_done", done, 1);
      chk("err_error", error, 1);
      chk("err_awvalid", axi.awvalid, 0);
      chk("err_arvalid", axi.arvalid, 0);
      tick(); #2;
      chk("err_done_low", done, 0);
      chk("err_error_hold", error, 1);
      chk("err_cmd_ready", cmd_ready, 1);
      tick();
   endtask

   task automatic run_write(input logic [AWD-1:0] addr, input logic [7:0] len, input int mode,
                            input logic [1:0] bresp, input logic [3:0] bid, input int abort_at);
      logic [AWD-1:0]  al;
      int              beats, idx, dly;
      bit              exp_err, fin;
      logic [DW-1:0]   dq[$];
      logic [DW/8-1:0] sq[$];
      al = addr & ~32'h3;
      beats = int'(len) + 1;
      for (int i = 0; i < beats; i++) begin
         dq.push_back($urandom);
         sq.push_back(4'($urandom));
      end
      exp_err = bresp[1] || (bid != MID);
      issue_cmd(1'b1, addr, len);
      if (crosses_4k(al, len)) begin
         check_err_cmd();
         $display("WR addr=0x%08h len=%0d crosses 4KB -> error", addr, len);
         return;
      end
      wr_valid = 1'b1; wr_data = dq[0]; wr_strb = sq[0];
      fin = 0;
      for (int cyc = 0; cyc < 64 && !fin; cyc++) begin
         axi.awready = pick(mode, cyc);
         #2;
         chk("awvalid", axi.awvalid, 1);
         chk("wvalid_before_aw", axi.wvalid, 0);
         chk("wr_ready_before_aw", wr_ready, 0);
         if (axi.awready) begin
            chk("awaddr", axi.awaddr, al);
            chk("awlen", axi.awlen, len);
            chk("awsize", axi.awsize, 2);
            chk("awburst", axi.awburst, 1);
            chk("awid", axi.awid, MID);
            fin = 1;
         end
         tick();
      end
      axi.awready = 1'b0;
      chk("aw_handshake_seen", fin, 1);
      idx = 0; fin = 0;
      for (int cyc = 0; cyc < 400 && !fin; cyc++) begin
         wr_valid   = (mode == 2) ? 1'($urandom_range(0, 1)) : 1'b1;
         axi.wready = pick(mode, cyc);
         wr_data = dq[idx]; wr_strb = sq[idx];
         #2;
         chk("wvalid", axi.wvalid, wr_valid);
         chk("wr_ready", wr_ready, axi.wready);
         if (wr_valid && axi.wready) begin
            chk("wdata", axi.wdata, dq[idx]);
            chk("wstrb", axi.wstrb, sq[idx]);
            chk("wlast", axi.wlast, idx == int'(len));
            idx++;
            if (idx == beats) fin = 1;
         end
         tick();
         if (abort_at >= 0 && idx == abort_at) begin
            wr_valid = 1'b1;
            aresetn = 1'b0;
            #1;
            chk("rst_wvalid", axi.wvalid, 0);
            chk("rst_cmd_ready", cmd_ready, 1);
            chk("rst_done", done, 0);
            chk("rst_error", error, 0);
            tick();
            aresetn = 1'b0;
            tick();
            aresetn = 1'b1; wr_valid = 1'b0; axi.wready = 1'b0;
            #2;
            chk("rst_release_cmd_ready", cmd_ready, 1);
            chk("rst_release_done", done, 0);
            tick();
            $display("WR addr=0x%08h len=%0d aborted by reset after %0d beats", addr, len, idx);
            return;
         end
      end
      wr_valid = 1'b0; axi.wready = 1'b0;
      chk("w_all_beats", idx, beats);
      dly = (mode == 0) ? 0 : $urandom_range(0, 3);
      fin = 0;
      for (int cyc = 0; cyc < 64 && !fin; cyc++) begin
         axi.bvalid = (cyc >= dly); axi.bid = bid; axi.bresp = bresp;
         #2;
         chk("bready", axi.bready, 1);
         if (axi.bvalid) begin
            chk("b_done", done, 1);
            chk("b_error", error, exp_err);
            fin = 1;
         end else begin
            chk("b_done_wait", done, 0);
         end
         tick();
      end
      axi.bvalid = 1'b0;
      #2;
      chk("wr_done_low", done, 0);
      chk("wr_error_hold", error, exp_err);
      chk("wr_cmd_ready", cmd_ready, 1);
      tick();
      $display("WR addr=0x%08h len=%0d mode=%0d bresp=%0d bid=%0d -> error=%0b", addr, len, mode, bresp, bid, exp_err);
   endtask

   task automatic run_read(input logic [AWD-1:0] addr, input logic [7:0] len, input int mode,
                           input int nbeats, input int bad_beat, input logic [3:0] rid);
      logic [AWD-1:0] al;
      int             idx;
      bit             exp_err, fin;
      logic [DW-1:0]  dq[$];
      al = addr & ~32'h3;
      for (int i = 0; i < nbeats; i++) dq.push_back($urandom);
      // Burst-level error rules: bad response/ID, early rlast, or a non-last beat past len
      exp_err = (rid != MID) || (bad_beat >= 0 && bad_beat < nbeats);
      for (int i = 0; i < nbeats; i++) begin
         if (i == nbeats - 1 && i < int'(len)) exp_err = 1;
         if (i != nbeats - 1 && i > int'(len)) exp_err = 1;
      end
      issue_cmd(1'b0, addr, len);
      if (crosses_4k(al, len)) begin
         check_err_cmd();
         $display("RD addr=0x%08h len=%0d crosses 4KB -> error", addr, len);
         return;
      end
      axi.rvalid = 1'b1; rd_ready = 1'b1;
      fin = 0;
      for (int cyc = 0; cyc < 64 && !fin; cyc++) begin
         axi.arready = pick(mode, cyc);
         #2;
         chk("arvalid", axi.arvalid, 1);
         chk("rd_valid_before_ar", rd_valid, 0);
         chk("rready_before_ar", axi.rready, 0);
         if (axi.arready) begin
            chk("araddr", axi.araddr, al);
            chk("arlen", axi.arlen, len);
            chk("arsize", axi.arsize, 2);
            chk("arburst", axi.arburst, 1);
            fin = 1;
         end
         tick();
      end
      axi.arready = 1'b0;
      chk("ar_handshake_seen", fin, 1);
      idx = 0; fin = 0;
      for (int cyc = 0; cyc < 400 && !fin; cyc++) begin
         axi.rvalid = (mode == 2) ? 1'($urandom_range(0, 1)) : 1'b1;
         axi.rdata  = dq[idx];
         axi.rlast  = (idx == nbeats - 1);
         axi.rresp  = (idx == bad_beat) ? 2'b10 : 2'b00;
         axi.rid    = rid;
         rd_ready   = pick(mode, cyc);
         #2;
         chk("rd_valid", rd_valid, axi.rvalid);
         chk("rready", axi.rready, rd_ready);
         if (axi.rvalid && rd_ready) begin
            chk("rd_data", rd_data, dq[idx]);
            if (axi.rlast) begin
               chk("r_done", done, 1);
               chk("r_error", error, exp_err);
               fin = 1;
            end else begin
               chk("r_done_mid", done, 0);
            end
            idx++;
         end
         tick();
      end
      axi.rvalid = 1'b0; axi.rlast = 1'b0; rd_ready = 1'b0;
      chk("r_beats", idx, nbeats);
      #2;
      chk("rd_done_low", done, 0);
      chk("rd_error_hold", error, exp_err);
      chk("rd_cmd_ready", cmd_ready, 1);
      tick();
      $display("RD addr=0x%08h len=%0d mode=%0d beats=%0d bad=%0d rid=%0d -> error=%0b", addr, len, mode, nbeats, bad_beat, rid, exp_err);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog expired: observed=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [AWD-1:0] addr;
      logic [7:0]     len;
      int             mode, nb, bad, sel;
      cmd_valid = 0; cmd_write = 0; cmd_addr = '0; cmd_len = '0;
      wr_data = '0; wr_strb = '0; wr_valid = 0; rd_ready = 0;
      axi.awready = 0; axi.wready = 0; axi.arready = 0;
      axi.bid = '0; axi.bresp = '0; axi.bvalid = 0;
      axi.rid = '0; axi.rdata = '0; axi.rresp = '0; axi.rlast = 0; axi.rvalid = 0;
      #3;
      chk("reset_cmd_ready", cmd_ready, 1);
      chk("reset_done", done, 0);
      chk("reset_error", error, 0);
      chk("reset_awvalid", axi.awvalid, 0);
      chk("reset_arvalid", axi.arvalid, 0);
      chk("reset_bready", axi.bready, 0);
      chk("reset_rready", axi.rready, 0);
      tick(); tick();
      aresetn = 1'b1;
      tick();

      run_write(32'h100, 8'd3, 0, 2'b00, MID, -1);
      run_read(32'h200, 8'd1, 1, 2, -1, MID);
      run_write(32'hFF8, 8'd3, 0, 2'b00, MID, -1);
      run_read(32'h400, 8'd3, 0, 2, 1, MID);
      run_write(32'h103, 8'd0, 1, 2'b10, MID, -1);
      run_write(32'h1F0, 8'd2, 2, 2'b01, 4'h5, -1);
      run_read(32'h3F0, 8'd2, 2, 6, -1, MID);
      run_read(32'h800, 8'd0, 0, 1, -1, 4'h2);
      run_read(32'hFFC, 8'd0, 0, 1, -1, MID);
      run_read(32'h1FFC, 8'd1, 0, 2, -1, MID);
      run_write(32'h300, 8'd3, 0, 2'b00, MID, 2);
      run_write(32'h300, 8'd3, 0, 2'b00, MID, -1);

      for (int t = 0; t < 24; t++) begin
         addr = ($urandom_range(0, 2) == 0) ? (($urandom & 32'hFFFF_F000) | (32'hFFF - 32'($urandom_range(0, 63))))
                                            : $urandom;
         len  = 8'($urandom_range(0, 15));
         mode = $urandom_range(0, 2);
         if ($urandom_range(0, 1) == 1) begin
            run_write(addr, len, mode, 2'($urandom_range(0, 3)),
                      ($urandom_range(0, 5) == 0) ? 4'h3 : MID, -1);
         end else begin
            sel = $urandom_range(0, 3);
            if (sel == 0 && len > 0) nb = $urandom_range(1, int'(len));
            else if (sel == 1)       nb = int'(len) + 3;
            else                     nb = int'(len) + 1;
            bad = ($urandom_range(0, 4) == 0) ? $urandom_range(0, nb - 1) : -1;
            run_read(addr, len, mode, nb, bad, ($urandom_range(0, 5) == 0) ? 4'h9 : MID);
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
